projection_accumulator: RTL and testbench
=========================================

# projection_accumulator

- Builds per-row and per-column counts of above-threshold pixels for one captured D5M frame.
- Sits between the capture/RAW2RGB pixel stream and the HPS PIO bridge.
- It is the write side that fills the row/column projection memories. The HPS then reads them back through a four-phase request/acknowledge port.
- One clock domain (pixel clock); the HPS side is expected to drive the read port from synchronized PIO bits.

## Interface
Parameters:
- WIDTH, 640, active pixels per line
- HEIGHT, 480, active lines per frame
- CNT_W, 10, width of each row/column count (saturating)

Ports:
- iCLK  in  1  sole clock; all logic rising-edge
- iRST  in  1  reset, synchronous, active-high
- iSTART  in  1  single-cycle pulse: arm capture of next frame
- iTHRESH  in  8  pixel counted when iDATA[11:4] > iTHRESH (strict, unsigned)
- iFVAL  in  1  frame valid
- iDVAL  in  1  pixel valid qualifier
- iDATA  in  12  pixel intensity
- iX_Cont  in  16  pixel column index
- iY_Cont  in  16  pixel row index
- oBUSY  out  1  high in CLEAR, WAIT_SOF, ACCUM, FLUSH
- oDONE  out  1  sticky: projections valid; cleared by iSTART or iRST
- oFRAME_PIXELS  out  19  total counted pixels in last frame
- iRD_REQ  in  1  read request (level, four-phase)
- iRD_SEL  in  1  0 = row memory, 1 = column memory
- iRD_ADDR  in  10  row or column index
- oRD_DATA  out  CNT_W  read data, valid while oRD_ACK high
- oRD_ACK  out  1  read acknowledge

## Operation
- Storage:
  - Row memory: HEIGHT x CNT_W.
  - Column memory: WIDTH x CNT_W.
  - Both single-port.
  - The read port only accesses them in IDLE or DONE.
- States: IDLE, CLEAR, WAIT_SOF, ACCUM, FLUSH, DONE.
- IDLE/DONE:
  - iSTART moves to CLEAR, clears oDONE and zeroes oFRAME_PIXELS.
  - iSTART in any other state is ignored.
- CLEAR:
  - Writes zero to address k of both memories on cycle k, for k = 0 .. max(WIDTH,HEIGHT)-1.
  - Out-of-range addresses are suppressed per memory.
  - Then moves to WAIT_SOF.
- WAIT_SOF:
  - Requires iFVAL sampled low at least once, then high.
  - On that rising edge, moves to ACCUM. A frame already in progress at arm time is skipped.
- ACCUM:
  - A pixel counts only when iDVAL=1, iX_Cont<WIDTH, iY_Cont<HEIGHT and the threshold test passes. Other pixels are ignored.
  - Row path:
    - Running register row_acc accumulates the current line.
    - When a counted-or-valid pixel arrives with iY_Cont different from the last row seen, the previous row_acc is written to row memory at the last row index.
    - row_acc then restarts at 0 or 1.
  - Column path:
    - 2-stage read-modify-write: stage 1 reads col[X]; stage 2 writes col[X]+1.
    - If the stage-2 address equals the stage-1 address, stage 1 takes the forwarded value instead of memory.
  - Sums saturate at 2^CNT_W-1.
  - oFRAME_PIXELS increments per counted pixel and saturates at 2^19-1.
  - iFVAL sampled low moves to FLUSH.
- FLUSH:
  - Commits the pending row_acc and drains the column pipeline.
  - Moves to DONE and sets oDONE.
- Read port:
  - In IDLE/DONE, with iRD_REQ=1 and oRD_ACK=0: latch iRD_SEL/iRD_ADDR and read memory.
  - Present oRD_DATA and raise oRD_ACK.
  - oRD_ACK holds until iRD_REQ=0, then drops; oRD_DATA holds its value.
  - Address >= HEIGHT (row) or >= WIDTH (column) returns 0 and still acknowledges.
  - While oBUSY=1 a request is held off (no ack) until DONE.
- iRST in any state:
  - Returns to IDLE.
  - Memory contents undefined; oDONE=0 marks them invalid.

## Timing
- Reset values: oBUSY=0, oDONE=0, oFRAME_PIXELS=0, oRD_DATA=0, oRD_ACK=0, row_acc=0, column pipeline valids=0.
- iSTART sampled at cycle t: oBUSY=1 at t+1.
- CLEAR lasts exactly max(WIDTH,HEIGHT) cycles.
- Column count updated in memory 2 cycles after its iDVAL cycle. Back-to-back pixels are accepted every cycle; no stall.
- iFVAL sampled low at cycle t in ACCUM: FLUSH at t+1, oDONE=1 and oBUSY=0 at t+3.
- Read: iRD_REQ sampled high at t (eligible state): oRD_ACK=1 and oRD_DATA valid at t+2.
- iRD_REQ sampled low at u: oRD_ACK=0 at u+1.
- Next request is accepted no earlier than u+1.
- iSTART and iRD_REQ in the same cycle in DONE: iSTART wins, the request waits, and it is acked after the next DONE.

## Test plan
- Reset:
  - Stimulus: assert iRST 2 cycles with iRD_REQ=1.
  - Required: all outputs 0, no ack until oDONE.
- All-bright frame:
  - Stimulus: WIDTH=8, HEIGHT=4, iTHRESH=0, every pixel 12'hFFF.
  - Required: every row reads 8, every column reads 4, oFRAME_PIXELS=32, oDONE at FVAL-fall+3.
- Diagonal frame:
  - Stimulus: WIDTH=8, HEIGHT=4; pixel bright only where X==Y, others 12'h000, iTHRESH=8'h10.
  - Required: rows 0-3 read 1, columns 0-3 read 1, columns 4-7 read 0, oFRAME_PIXELS=4.
- Re-arm:
  - Stimulus: second iSTART after a bright frame, then an all-dark frame.
  - Required: all rows/columns read 0, oFRAME_PIXELS=0.
  - Stimulus: iSTART while mid-frame.
  - Required: that frame is skipped.
- Handshake:
  - Stimulus: request column 2 during ACCUM.
  - Required: no ack until DONE, then ack with data.
  - Stimulus: iRD_ADDR=9 with iRD_SEL=1.
  - Required: data 0, ack 2 cycles after request.
  - Stimulus: drop iRD_REQ.
  - Required: ack falls next cycle.
- Reset mid-ACCUM:
  - Stimulus: iRST mid-ACCUM, then a full all-bright frame.
  - Required: oBUSY=0 and oDONE=0 after reset; the following frame yields the correct row/column counts.

Source files
------------

// File: rtl/projection_accumulator.sv
// Row/column projection builder for one captured frame: counts above-threshold pixels per
// line and per column, then serves the counts through a four-phase request/acknowledge port.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | nothing captured since reset; read port open
// CLEAR    | zeroing both projection memories, one address per cycle
// WAIT_SOF | armed; waiting for a full low-then-high frame-valid edge
// ACCUM    | counting pixels of the captured frame
// FLUSH    | committing the open row and draining the column pipeline
// DONE     | projections valid; read port open
module projection_accumulator #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int CNT_W  = 10
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iSTART,
  input  logic [7:0]       iTHRESH,
  input  logic             iFVAL,
  input  logic             iDVAL,
  input  logic [11:0]      iDATA,
  input  logic [15:0]      iX_Cont,
  input  logic [15:0]      iY_Cont,
  output logic             oBUSY,
  output logic             oDONE,
  output logic [18:0]      oFRAME_PIXELS,
  input  logic             iRD_REQ,
  input  logic             iRD_SEL,
  input  logic [9:0]       iRD_ADDR,
  output logic [CNT_W-1:0] oRD_DATA,
  output logic             oRD_ACK
);

  localparam int MAX_WH = (WIDTH > HEIGHT) ? WIDTH : HEIGHT;
  localparam int ROW_AW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int COL_AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CLR_W  = $clog2(MAX_WH + 1);

  localparam logic [15:0]      WIDTH_16  = 16'(WIDTH);
  localparam logic [15:0]      HEIGHT_16 = 16'(HEIGHT);
  localparam logic [CLR_W-1:0] CLR_LAST  = CLR_W'(MAX_WH - 1);
  localparam logic [CLR_W-1:0] WIDTH_C   = CLR_W'(WIDTH);
  localparam logic [CLR_W-1:0] HEIGHT_C  = CLR_W'(HEIGHT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [18:0]      PIX_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_SOF,
    S_ACCUM,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [CLR_W-1:0]  clr_addr;
  logic              fval_low_seen;
  logic              flush_cnt;

  logic [CNT_W-1:0]  row_mem [HEIGHT];
  logic [CNT_W-1:0]  col_mem [WIDTH];

  logic [COL_AW-1:0] x_idx;
  logic [ROW_AW-1:0] y_idx;
  logic              pix_valid;
  logic              pix_hit;
  logic              row_change;
  logic              flush_commit;
  logic              port_open;

  logic [CNT_W-1:0]  row_acc;
  logic [ROW_AW-1:0] last_row;
  logic              row_seen;

  logic              col_vld;
  logic [COL_AW-1:0] col_addr;
  logic [CNT_W-1:0]  col_data;
  logic [CNT_W-1:0]  col_inc;
  logic              col_fwd;

  logic              row_wr_en;
  logic [ROW_AW-1:0] row_wr_addr;
  logic [CNT_W-1:0]  row_wr_data;
  logic              col_wr_en;
  logic [COL_AW-1:0] col_wr_addr;
  logic [CNT_W-1:0]  col_wr_data;

  logic              rd_accept;
  logic              rd_pend;
  logic              rd_sel_q;
  logic [9:0]        rd_addr_q;
  logic [CNT_W-1:0]  rd_value;

  logic              unused_data_lsbs;
  assign unused_data_lsbs = ^iDATA[3:0];

  assign x_idx        = iX_Cont[COL_AW-1:0];
  assign y_idx        = iY_Cont[ROW_AW-1:0];
  assign pix_valid    = (state == S_ACCUM) && iDVAL && (iX_Cont < WIDTH_16) && (iY_Cont < HEIGHT_16);
  assign pix_hit      = pix_valid && (iDATA[11:4] > iTHRESH);
  assign row_change   = pix_valid && (!row_seen || (y_idx != last_row));
  assign flush_commit = (state == S_FLUSH) && flush_cnt && row_seen;
  assign port_open    = (state == S_IDLE) || (state == S_DONE);

  assign oBUSY = (state == S_CLEAR) || (state == S_WAIT_SOF) ||
                 (state == S_ACCUM) || (state == S_FLUSH);

  always_ff @(posedge iCLK) begin
    if (iRST) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: if (iSTART) state_next = S_CLEAR;
      S_CLEAR:        if (clr_addr == CLR_LAST) state_next = S_WAIT_SOF;
      S_WAIT_SOF:     if (fval_low_seen && iFVAL) state_next = S_ACCUM;
      S_ACCUM:        if (!iFVAL) state_next = S_FLUSH;
      S_FLUSH:        if (!flush_cnt) state_next = S_DONE;
      default:        state_next = S_IDLE;
    endcase
  end

  // Sequencing counters: clear address, start-of-frame qualifier, two-cycle flush timer.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      clr_addr      <= '0;
      fval_low_seen <= 1'b0;
      flush_cnt     <= 1'b0;
    end else begin
      if (state == S_CLEAR) clr_addr <= clr_addr + CLR_W'(1);
      else                  clr_addr <= '0;

      if (state != S_WAIT_SOF) fval_low_seen <= 1'b0;
      else if (!iFVAL)         fval_low_seen <= 1'b1;

      if (state == S_ACCUM)      flush_cnt <= 1'b1;
      else if (state == S_FLUSH) flush_cnt <= 1'b0;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oDONE         <= 1'b0;
      oFRAME_PIXELS <= '0;
    end else begin
      if (port_open && iSTART)                 oDONE <= 1'b0;
      else if ((state == S_FLUSH) && !flush_cnt) oDONE <= 1'b1;

      if (port_open && iSTART)                      oFRAME_PIXELS <= '0;
      else if (pix_hit && (oFRAME_PIXELS != PIX_MAX)) oFRAME_PIXELS <= oFRAME_PIXELS + 19'd1;
    end
  end

  // Row path: one open line total, written back when the line index moves on.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      row_acc  <= '0;
      last_row <= '0;
      row_seen <= 1'b0;
    end else if (state == S_CLEAR) begin
      row_acc  <= '0;
      row_seen <= 1'b0;
    end else if (row_change) begin
      row_acc  <= pix_hit ? CNT_W'(1) : '0;
      last_row <= y_idx;
      row_seen <= 1'b1;
    end else if (pix_hit && (row_acc != CNT_MAX)) begin
      row_acc <= row_acc + CNT_W'(1);
    end else if (flush_commit) begin
      row_acc  <= '0;
      row_seen <= 1'b0;
    end
  end

  // Column path: read stage registers col[X]; the following cycle writes it back incremented.
  assign col_inc = (col_data == CNT_MAX) ? CNT_MAX : col_data + CNT_W'(1);
  assign col_fwd = col_vld && (col_addr == x_idx);

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      col_vld  <= 1'b0;
      col_addr <= '0;
      col_data <= '0;
    end else begin
      col_vld <= pix_hit;
      if (pix_hit) begin
        col_addr <= x_idx;
        col_data <= col_fwd ? col_inc : col_mem[x_idx];
      end
    end
  end

  always_comb begin
    row_wr_en   = 1'b0;
    row_wr_addr = last_row;
    row_wr_data = row_acc;
    col_wr_en   = col_vld;
    col_wr_addr = col_addr;
    col_wr_data = col_inc;
    if (state == S_CLEAR) begin
      row_wr_en   = clr_addr < HEIGHT_C;
      row_wr_addr = clr_addr[ROW_AW-1:0];
      row_wr_data = '0;
      col_wr_en   = clr_addr < WIDTH_C;
      col_wr_addr = clr_addr[COL_AW-1:0];
      col_wr_data = '0;
    end else begin
      row_wr_en = (row_change && row_seen) || flush_commit;
    end
  end

  always_ff @(posedge iCLK) begin
    if (row_wr_en) row_mem[row_wr_addr] <= row_wr_data;
    if (col_wr_en) col_mem[col_wr_addr] <= col_wr_data;
  end

  // Read port: a start pulse takes priority, so a coincident request waits for the next DONE.
  assign rd_accept = port_open && !iSTART && iRD_REQ && !oRD_ACK && !rd_pend;

  always_comb begin
    rd_value = '0;
    if (rd_sel_q) begin
      if ({6'd0, rd_addr_q} < WIDTH_16) rd_value = col_mem[rd_addr_q[COL_AW-1:0]];
    end else if ({6'd0, rd_addr_q} < HEIGHT_16) begin
      rd_value = row_mem[rd_addr_q[ROW_AW-1:0]];
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      rd_pend   <= 1'b0;
      rd_sel_q  <= 1'b0;
      rd_addr_q <= '0;
      oRD_ACK   <= 1'b0;
      oRD_DATA  <= '0;
    end else begin
      rd_pend <= rd_accept;
      if (rd_accept) begin
        rd_sel_q  <= iRD_SEL;
        rd_addr_q <= iRD_ADDR;
      end
      if (rd_pend) begin
        oRD_ACK  <= 1'b1;
        oRD_DATA <= rd_value;
      end else if (oRD_ACK && !iRD_REQ) begin
        oRD_ACK <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_projection_accumulator.sv
// Scoreboard bench for projection_accumulator on a small 8x4 frame: a counting model fills the
// expected projections, reads push expected data, and a monitor checks each acknowledge.
module tb_projection_accumulator;
  localparam int W    = 8;
  localparam int H    = 4;
  localparam int CW   = 10;
  localparam int CMAX = (1 << CW) - 1;

  logic          iCLK = 1'b0;
  logic          iRST;
  logic          iSTART;
  logic [7:0]    iTHRESH;
  logic          iFVAL;
  logic          iDVAL;
  logic [11:0]   iDATA;
  logic [15:0]   iX_Cont;
  logic [15:0]   iY_Cont;
  logic          oBUSY;
  logic          oDONE;
  logic [18:0]   oFRAME_PIXELS;
  logic          iRD_REQ;
  logic          iRD_SEL;
  logic [9:0]    iRD_ADDR;
  logic [CW-1:0] oRD_DATA;
  logic          oRD_ACK;

  projection_accumulator #(.WIDTH(W), .HEIGHT(H), .CNT_W(CW)) dut (
    .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iTHRESH(iTHRESH),
    .iFVAL(iFVAL), .iDVAL(iDVAL), .iDATA(iDATA), .iX_Cont(iX_Cont), .iY_Cont(iY_Cont),
    .oBUSY(oBUSY), .oDONE(oDONE), .oFRAME_PIXELS(oFRAME_PIXELS),
    .iRD_REQ(iRD_REQ), .iRD_SEL(iRD_SEL), .iRD_ADDR(iRD_ADDR),
    .oRD_DATA(oRD_DATA), .oRD_ACK(oRD_ACK)
  );

  always #5 iCLK = ~iCLK;

  int         checks = 0;
  int         errors = 0;
  int         exp_q[$];
  int         exp_row[H];
  int         exp_col[W];
  int         exp_pix;
  logic [7:0] cur_thr;
  logic       ack_prev = 1'b0;

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, req, $time);
    end
  endtask

  // Monitor: every rising acknowledge consumes one expected read value.
  always @(negedge iCLK) begin
    if (oRD_ACK && !ack_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected_ack actual=%0d expected=no_ack", oRD_DATA);
      end else begin
        check("rd_data", int'(oRD_DATA), exp_q.pop_front());
      end
    end
    ack_prev = oRD_ACK;
  end

  task automatic put_pix(input logic dv, input int x, input int y, input logic [11:0] d);
    iDVAL   = dv;
    iX_Cont = 16'(x);
    iY_Cont = 16'(y);
    iDATA   = d;
    if (dv && x < W && y < H && int'(d >> 4) > int'(cur_thr)) begin
      if (exp_row[y] < CMAX) exp_row[y]++;
      if (exp_col[x] < CMAX) exp_col[x]++;
      exp_pix++;
    end
    @(posedge iCLK); #1;
  endtask

  // kind: 0 all bright, 1 diagonal, 2 all dark, 3 random with gaps and out-of-range pixels
  task automatic frame(input int kind, input logic [7:0] thr, input bit arm);
    int n;
    int extra_x;
    int extra_y;
    logic [11:0] d;
    foreach (exp_row[i]) exp_row[i] = 0;
    foreach (exp_col[i]) exp_col[i] = 0;
    exp_pix = 0;
    cur_thr = thr;
    iTHRESH = thr;
    extra_x = (kind == 3) ? 2 : 0;
    extra_y = (kind == 3) ? 1 : 0;
    if (arm) begin
      iSTART = 1'b1;
      @(posedge iCLK); #1;
      iSTART = 1'b0;
      check("busy_on_start", int'(oBUSY), 1);
      check("done_cleared", int'(oDONE), 0);
      check("pix_cleared", int'(oFRAME_PIXELS), 0);
    end
    iFVAL = 1'b0;
    iDVAL = 1'b0;
    repeat (12) @(posedge iCLK);
    #1 iFVAL = 1'b1;
    put_pix(0, 0, 0, 12'h000);
    put_pix(0, 0, 0, 12'h000);
    for (int y = 0; y < H + extra_y; y++) begin
      for (int x = 0; x < W + extra_x; x++) begin
        case (kind)
          0:       d = 12'hFFF;
          1:       d = (x == y) ? 12'hFFF : 12'h000;
          2:       d = 12'h000;
          default: d = 12'($urandom_range(0, 4095));
        endcase
        if (kind == 3 && $urandom_range(0, 3) == 0) put_pix(0, x, y, 12'hFFF);
        put_pix(1, x, y, d);
      end
      put_pix(0, 0, y, 12'h000);
      put_pix(0, 0, y, 12'h000);
    end
    iFVAL = 1'b0;
    iDVAL = 1'b0;
    n = 0;
    do begin
      @(posedge iCLK);
      n++;
      @(negedge iCLK);
    end while (!oDONE && n < 20);
    check("done_latency", n, 3);
    check("busy_at_done", int'(oBUSY), 0);
    check("frame_pixels", int'(oFRAME_PIXELS), exp_pix);
    @(posedge iCLK); #1;
  endtask

  // lat >= 0: required cycles from request sample to ack; lat < 0: ack must coincide with DONE
  task automatic rd(input logic sel, input int addr, input int expv, input int lat);
    int n;
    exp_q.push_back(expv);
    iRD_SEL  = sel;
    iRD_ADDR = 10'(addr);
    iRD_REQ  = 1'b1;
    n = 0;
    do begin
      @(posedge iCLK);
      n++;
      @(negedge iCLK);
    end while (!oRD_ACK && n < 3000);
    if (!oRD_ACK) begin
      checks++;
      errors++;
      $display("FAIL rd_timeout actual=no_ack expected=ack sel=%0d addr=%0d", sel, addr);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
    end else if (lat >= 0) begin
      check("rd_latency", n, lat);
    end else begin
      check("rd_held_until_done", int'(oDONE), 1);
    end
    @(posedge iCLK); #1;
    iRD_REQ = 1'b0;
    @(posedge iCLK);
    @(negedge iCLK);
    check("ack_drop", int'(oRD_ACK), 0);
    check("rd_data_hold", int'(oRD_DATA), expv);
    @(posedge iCLK); #1;
  endtask

  task automatic readback();
    for (int r = 0; r < H; r++) rd(1'b0, r, exp_row[r], 2);
    for (int c = 0; c < W; c++) rd(1'b1, c, exp_col[c], 2);
  endtask

  initial begin
    iRST = 1'b1; iSTART = 1'b0; iTHRESH = 8'h00; iFVAL = 1'b0; iDVAL = 1'b0;
    iDATA = 12'h000; iX_Cont = 16'h0; iY_Cont = 16'h0;
    iRD_REQ = 1'b1; iRD_SEL = 1'b0; iRD_ADDR = 10'h0;
    cur_thr = 8'h00;
    exp_pix = 0;

    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    check("rst_busy", int'(oBUSY), 0);
    check("rst_done", int'(oDONE), 0);
    check("rst_pix", int'(oFRAME_PIXELS), 0);
    check("rst_rd_data", int'(oRD_DATA), 0);
    check("rst_rd_ack", int'(oRD_ACK), 0);
    @(posedge iCLK); #1;
    iRST = 1'b0;
    iRD_REQ = 1'b0;

    frame(0, 8'h00, 1'b1);
    readback();
    rd(1'b1, 9, 0, 2);
    rd(1'b0, 4, 0, 2);
    rd(1'b0, 1023, 0, 2);

    frame(1, 8'h10, 1'b1);
    readback();

    frame(2, 8'h00, 1'b1);
    readback();

    fork
      frame(0, 8'h00, 1'b1);
      begin
        repeat (30) @(posedge iCLK);
        #1 rd(1'b1, 2, H, -1);
      end
    join
    readback();

    fork
      frame(0, 8'h00, 1'b1);
      rd(1'b1, 3, H, -1);
    join
    readback();

    // Arm in the middle of a bright frame: that frame must be skipped in favour of the dark one.
    cur_thr = 8'h00;
    iTHRESH = 8'h00;
    iFVAL   = 1'b1;
    put_pix(0, 0, 0, 12'h000);
    iSTART = 1'b1;
    put_pix(1, 0, 0, 12'hFFF);
    iSTART = 1'b0;
    check("busy_on_midframe_start", int'(oBUSY), 1);
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < W + 2; x++) put_pix(x < W ? 1'b1 : 1'b0, x, y, 12'hFFF);
    frame(2, 8'h00, 1'b0);
    readback();

    // Reset in the middle of accumulation, then a clean bright frame.
    iSTART = 1'b1;
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    repeat (12) @(posedge iCLK);
    #1 iFVAL = 1'b1;
    for (int i = 0; i < 12; i++) put_pix(1, i % W, i / W, 12'hFFF);
    iRST = 1'b1;
    @(posedge iCLK); #1;
    @(posedge iCLK); #1;
    check("midrst_busy", int'(oBUSY), 0);
    check("midrst_done", int'(oDONE), 0);
    check("midrst_pix", int'(oFRAME_PIXELS), 0);
    iRST  = 1'b0;
    iFVAL = 1'b0;
    iDVAL = 1'b0;
    @(posedge iCLK); #1;
    frame(0, 8'h00, 1'b1);
    readback();

    for (int f = 0; f < 3; f++) begin
      frame(3, 8'($urandom_range(0, 255)), 1'b1);
      readback();
    end

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover actual=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
